vreg_group_seq: RTL and testbench

- Parametrised successor to the vector-register address generator.
- Walks a register group (base register + reg index, inner element-offset loop) and emits one (addr, off) beat per cycle.
- Adds valid/ready handshakes on both sides, output backpressure, a vstart-style start offset, and bubble-free back-to-back requests.
- Sits between the instruction issue stage and the VRF read/write port sequencer.

---
 rtl/vreg_group_seq_pkg.sv | 20 ++
 rtl/vreg_group_seq_if.sv | 43 ++++
 rtl/vreg_group_seq_ctr.sv | 68 ++++++
 rtl/vreg_group_seq.sv | 85 ++++++++
 tb/tb_vreg_group_seq.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vreg_group_seq_pkg.sv
// Shared types and default widths for the vector register group sequencer.
// Holds the state enum, default parameter values and the request bundle.
package vreg_seq_pkg;

  localparam int ADDR_W = 5;
  localparam int OFF_W  = 8;
  localparam int REG_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [REG_W-1:0]  max_reg;
    logic [OFF_W-1:0]  max_off;
  } req_t;

endpackage

// File: rtl/vreg_group_seq_if.sv
// Request and beat handshake bundle for vreg_group_seq.
// master: issue side / beat consumer; slave: the sequencer.
interface vreg_group_seq_if
  import vreg_seq_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int OW = OFF_W,
  parameter int RW = REG_W
);

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_base;
  logic [RW-1:0] req_max_reg;
  logic [OW-1:0] req_max_off;
  logic [OW-1:0] req_start_off;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [OW-1:0] out_off;
  logic          out_start;
  logic          out_end;
  logic          busy;

  modport master (
    output req_valid, req_base,
    output req_max_reg, req_max_off,
    output req_start_off, out_ready,
    input  req_ready, out_valid,
    input  out_addr, out_off,
    input  out_start, out_end, busy
  );

  modport slave (
    input  req_valid, req_base,
    input  req_max_reg, req_max_off,
    input  req_start_off, out_ready,
    output req_ready, out_valid,
    output out_addr, out_off,
    output out_start, out_end, busy
  );

endinterface

// File: rtl/vreg_group_seq_ctr.sv
// Two-level (reg, off) counter: load, advance, registered terminal count.
// Ports: load/adv controls, limits + start offset in, off/wrap/tc out.
module vreg_nested_ctr #(
  parameter int RW = 3,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          adv,
  input  logic [RW-1:0] ld_max_reg,
  input  logic [OW-1:0] ld_max_off,
  input  logic [OW-1:0] ld_off,
  output logic [OW-1:0] off,
  output logic          wrap,
  output logic          tc
);

  logic [RW-1:0] reg_q, reg_d;
  logic [OW-1:0] off_q, off_d;
  logic [RW-1:0] mreg_q, mreg_d;
  logic [OW-1:0] moff_q, moff_d;
  logic          tc_q, tc_d;

  assign wrap = off_q == moff_q;

  always_comb begin
    reg_d  = reg_q;
    off_d  = off_q;
    mreg_d = mreg_q;
    moff_d = moff_q;
    if (load) begin
      reg_d  = '0;
      off_d  = ld_off;
      mreg_d = ld_max_reg;
      moff_d = ld_max_off;
    end else if (adv) begin
      if (wrap) begin
        off_d = '0;
        reg_d = reg_q + RW'(1);
      end else begin
        off_d = off_q + OW'(1);
      end
    end
    // end flag is precomputed so it lands with the beat it marks
    tc_d = (reg_d == mreg_d) && (off_d == moff_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q  <= '0;
      off_q  <= '0;
      mreg_q <= '0;
      moff_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      reg_q  <= reg_d;
      off_q  <= off_d;
      mreg_q <= mreg_d;
      moff_q <= moff_d;
      tc_q   <= tc_d;
    end
  end

  assign off = off_q;
  assign tc  = tc_q;

endmodule

// File: rtl/vreg_group_seq.sv
// Register-group address sequencer: one (addr, off) beat per cycle.
// Ports: clk, rst_n (async low), bus (request in, beat out, busy).
module vreg_group_seq
  import vreg_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int OFF_WIDTH  = OFF_W,
  parameter int REG_WIDTH  = REG_W
) (
  input logic             clk,
  input logic             rst_n,
  vreg_group_seq_if.slave bus
);

  state_t                state;
  logic                  vld_q;
  logic                  start_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [OFF_WIDTH-1:0]  off;
  logic [OFF_WIDTH-1:0]  ld_off;
  logic                  wrap;
  logic                  tc;
  logic                  fire;
  logic                  last;
  logic                  accept;
  logic                  adv;
  logic                  ready;

  assign fire   = vld_q & bus.out_ready;
  assign last   = fire & tc;
  assign adv    = fire & ~tc;
  assign ready  = (state == IDLE) | last;
  assign accept = bus.req_valid & ready;

  // vstart beyond the register length collapses to the last element
  assign ld_off = (bus.req_start_off > bus.req_max_off)
                ? bus.req_max_off : bus.req_start_off;

  vreg_nested_ctr #(
    .RW(REG_WIDTH),
    .OW(OFF_WIDTH)
  ) u_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .adv       (adv),
    .ld_max_reg(bus.req_max_reg),
    .ld_max_off(bus.req_max_off),
    .ld_off    (ld_off),
    .off       (off),
    .wrap      (wrap),
    .tc        (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      vld_q   <= 1'b0;
      start_q <= 1'b0;
      addr_q  <= '0;
    end else if (accept) begin
      state   <= BUSY;
      vld_q   <= 1'b1;
      start_q <= 1'b1;
      addr_q  <= bus.req_base;
    end else if (last) begin
      state   <= IDLE;
      vld_q   <= 1'b0;
      start_q <= 1'b0;
    end else if (adv) begin
      start_q <= 1'b0;
      // address tracks base+reg; overflow wraps silently
      if (wrap) addr_q <= addr_q + ADDR_WIDTH'(1);
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_valid = vld_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_off   = off;
  assign bus.out_start = start_q;
  assign bus.out_end   = tc;
  assign bus.busy      = vld_q;

endmodule

// File: tb/tb_vreg_group_seq.sv
// Scoreboard bench for vreg_group_seq with directed and random requests.
// Expected beats come from a linear-index model of the register group walk.
module tb_vreg_group_seq;
  import vreg_seq_pkg::*;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] off;
    logic       st;
    logic       en;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  vreg_group_seq_if bus();

  vreg_group_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    beats_seen = 0;
  bit    rnd_ready = 1'b0;
  bit    hold = 1'b0;
  logic [15:0] hold_v;
  bit    acc_on_end;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_req(req_t r, int start);
    int so;
    int len;
    int total;
    beat_t b;
    len = int'(r.max_off) + 1;
    so = (start > int'(r.max_off)) ? int'(r.max_off) : start;
    total = (int'(r.max_reg) + 1) * len - so;
    for (int k = 0; k < total; k++) begin
      int idx;
      idx = k + so;
      b.addr = 5'((int'(r.base) + idx / len) % 32);
      b.off = 8'(idx % len);
      b.st = (k == 0);
      b.en = (k == total - 1);
      exp_q.push_back(b);
    end
  endfunction

  // monitor: checks against model, pops beats, then records accepts
  always @(negedge clk) begin
    beat_t e;
    req_t r;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold)
        check("hold_stable",
              {bus.out_valid, bus.out_addr, bus.out_off,
               bus.out_start, bus.out_end}, hold_v);
      check("out_valid", bus.out_valid, exp_q.size() != 0);
      check("busy", bus.busy, exp_q.size() != 0);
      check("req_ready", bus.req_ready,
            exp_q.size() == 0 ||
            (exp_q.size() == 1 && bus.out_ready));
      hold = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        hold = 1'b1;
        hold_v = {bus.out_valid, bus.out_addr, bus.out_off,
                  bus.out_start, bus.out_end};
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat",
                {bus.out_addr, bus.out_off,
                 bus.out_start, bus.out_end},
                {e.addr, e.off, e.st, e.en});
          beats_seen++;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        r.base = bus.req_base;
        r.max_reg = bus.req_max_reg;
        r.max_off = bus.req_max_off;
        push_req(r, int'(bus.req_start_off));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic scramble();
    bus.req_base = 5'($urandom);
    bus.req_max_reg = 3'($urandom);
    bus.req_max_off = 8'($urandom);
    bus.req_start_off = 8'($urandom);
  endtask

  task automatic send(int b, int mr, int mo, int so);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_base = 5'(b);
    bus.req_max_reg = 3'(mr);
    bus.req_max_off = 8'(mo);
    bus.req_start_off = 8'(so);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        acc_on_end = bus.out_valid && bus.out_end;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  initial begin
    int stalls;
    int b0;
    bit ok;
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    scramble();
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_ready", bus.req_ready, 1);
    check("rst_data",
          {bus.out_addr, bus.out_off, bus.out_start,
           bus.out_end, bus.busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // basic walk, vstart, clamp to single beat
    send(4, 1, 2, 0);
    wait_idle();
    send(8, 0, 3, 2);
    wait_idle();
    send(8, 0, 3, 7);
    wait_idle();

    // three-cycle stall on beat (4,2)
    stalls = 0;
    send(4, 1, 2, 0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid && bus.out_addr == 5'd4 &&
          bus.out_off == 8'd2 && stalls < 3) begin
        bus.out_ready = 1'b0;
        stalls++;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (exp_q.size() == 0 && !bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_done", ok, 1);
    check("bp_stalls", stalls, 3);
    bus.out_ready = 1'b1;

    // back-to-back: B waits for A's last beat
    send(4, 1, 2, 0);
    send(20, 0, 0, 0);
    check("b2b_on_last", acc_on_end, 1);
    @(negedge clk);
    check("b2b_no_bubble",
          {bus.out_valid, bus.out_addr,
           bus.out_start, bus.out_end},
          {1'b1, 5'd20, 1'b1, 1'b1});
    wait_idle();

    // address wrap
    send(31, 2, 0, 0);
    wait_idle();

    // reset on beat 3 of the basic walk
    b0 = beats_seen;
    send(4, 1, 2, 0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (beats_seen >= b0 + 3) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_reach_beat3", ok, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", bus.req_ready, 1);
    send(4, 1, 2, 0);
    wait_idle();

    // random requests with random backpressure and gaps
    rnd_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      send(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 5)), int'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
